// File: rtl/v_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : v_regfile_mp
// Purpose  : Multi-read-port vector register file with element-masked
//            writeback, per-register busy scoreboard and optional same-cycle
//            write-to-read forwarding (enabled by defining VREG_BYPASS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module v_regfile_mp #(
    parameter int VLEN  = 256,
    parameter int ELEN  = 32,
    parameter int NREG  = 32,
    parameter int NRD   = 3,
    parameter int ZERO0 = 1,
    localparam int NELEM = VLEN / ELEN,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wb_en_i,
    input  logic [AW-1:0]       wb_addr_i,
    input  logic [VLEN-1:0]     wb_data_i,
    input  logic [NELEM-1:0]    wb_mask_i,
    input  logic                wb_last_i,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_addr_i,
    input  logic [NRD-1:0]      rd_en_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*VLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    output logic [NREG-1:0]     busy_o,
    output logic                sb_err_o
);

    logic [VLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            sb_err;
    logic            err_set;
    logic [VLEN-1:0] wb_bitmask;
    logic            wb_zero;
    logic            iss_zero;

    always_comb begin
        wb_bitmask = '0;
        for (int k = 0; k < NELEM; k++) begin
            wb_bitmask[k*ELEN +: ELEN] = {ELEN{wb_mask_i[k]}};
        end
    end

    // With ZERO0 set, register 0 is inert: writes, issues and clears to it vanish.
    assign wb_zero  = (ZERO0 != 0) && (wb_addr_i == '0);
    assign iss_zero = (ZERO0 != 0) && (iss_addr_i == '0);

    always_comb begin
        busy_nxt = busy;
        err_set  = 1'b0;
        if (wb_en_i && wb_last_i && !wb_zero) begin
            busy_nxt[wb_addr_i] = 1'b0;
            if (!busy[wb_addr_i] && !(iss_en_i && iss_addr_i == wb_addr_i)) begin
                err_set = 1'b1;
            end
        end
        // Applied last so a same-cycle issue overrides the writeback clear.
        if (iss_en_i && !iss_zero) begin
            busy_nxt[iss_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
            busy   <= '0;
            sb_err <= 1'b0;
        end else begin
            if (wb_en_i && !wb_zero) begin
                regs[wb_addr_i] <= (regs[wb_addr_i] & ~wb_bitmask) | (wb_data_i & wb_bitmask);
            end
            busy <= busy_nxt;
            if (err_set) begin
                sb_err <= 1'b1;
            end
        end
    end

    assign busy_o   = busy;
    assign sb_err_o = sb_err;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            valid;
        logic [VLEN-1:0] merged;
        logic            clr;

        assign addr  = rd_addr_i[p*AW +: AW];
        assign valid = rst_n && rd_en_i[p] && !((ZERO0 != 0) && (addr == '0));
`ifdef VREG_BYPASS_EN
        logic fwd;
        assign fwd    = wb_en_i && (wb_addr_i == addr);
        assign merged = fwd ? ((regs[addr] & ~wb_bitmask) | (wb_data_i & wb_bitmask))
                            : regs[addr];
        assign clr    = fwd && wb_last_i && !(iss_en_i && iss_addr_i == addr);
`else
        assign merged = regs[addr];
        assign clr    = 1'b0;
`endif
        assign rd_data_o[p*VLEN +: VLEN] = valid ? merged : '0;
        assign rd_busy_o[p]              = valid && busy[addr] && !clr;
    end

endmodule
`default_nettype wire

// File: tb/tb_v_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_v_regfile_mp
// Purpose  : Directed self-checking bench for v_regfile_mp (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_v_regfile_mp;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         wb_en_i = 1'b0;
    logic [4:0]   wb_addr_i = '0;
    logic [255:0] wb_data_i = '0;
    logic [7:0]   wb_mask_i = '0;
    logic         wb_last_i = 1'b0;
    logic         iss_en_i = 1'b0;
    logic [4:0]   iss_addr_i = '0;
    logic [2:0]   rd_en_i = '0;
    logic [14:0]  rd_addr_i = '0;
    logic [767:0] rd_data_o;
    logic [2:0]   rd_busy_o;
    logic [31:0]  busy_o;
    logic         sb_err_o;

    int n_cmp = 0;
    int n_err = 0;

    v_regfile_mp dut (
        .clk(clk), .rst_n(rst_n),
        .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .wb_mask_i(wb_mask_i), .wb_last_i(wb_last_i),
        .iss_en_i(iss_en_i), .iss_addr_i(iss_addr_i),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o),
        .busy_o(busy_o), .sb_err_o(sb_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] pd(input int p);
        return rd_data_o[p*256 +: 256];
    endfunction

    task automatic set_rd(input int p, input logic [4:0] a);
        rd_en_i[p] = 1'b1;
        rd_addr_i[p*5 +: 5] = a;
    endtask

    task automatic wb(input logic [4:0] a, input logic [255:0] d, input logic [7:0] m,
                      input logic last);
        @(negedge clk);
        wb_en_i = 1'b1; wb_addr_i = a; wb_data_i = d; wb_mask_i = m; wb_last_i = last;
        @(posedge clk); #1;
        wb_en_i = 1'b0; wb_last_i = 1'b0; wb_mask_i = '0;
    endtask

    task automatic iss(input logic [4:0] a);
        @(negedge clk);
        iss_en_i = 1'b1; iss_addr_i = a;
        @(posedge clk); #1;
        iss_en_i = 1'b0;
    endtask

    task automatic async_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [255:0] pat;
        pat = {8{32'h5A5A_1234}};
        #2 rst_n = 1'b0;
        #2;
        n_cmp++; if (busy_o !== 32'h0) begin n_err++; $display("FAIL reset_busy: got %h want 0", busy_o); end
        n_cmp++; if (sb_err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", sb_err_o); end
        release_reset();
        wb(5'd2, pat, 8'hFF, 1'b0);
        iss(5'd4);
        wb(5'd10, '0, 8'h00, 1'b1);
        set_rd(0, 5'd2);
        #1;
        n_cmp++; if (pd(0) !== pat) begin n_err++; $display("FAIL prereset_data: got %h want %h", pd(0), pat); end
        async_reset();
        n_cmp++; if (pd(0) !== 256'h0) begin n_err++; $display("FAIL midreset_data: got %h want 0", pd(0)); end
        n_cmp++; if (busy_o !== 32'h0) begin n_err++; $display("FAIL midreset_busy: got %h want 0", busy_o); end
        n_cmp++; if (sb_err_o !== 1'b0) begin n_err++; $display("FAIL midreset_err: got %b want 0", sb_err_o); end
        release_reset();
        #1;
        n_cmp++; if (pd(0) !== 256'h0) begin n_err++; $display("FAIL postreset_data: got %h want 0", pd(0)); end
    endtask

    task automatic test_masked_write();
        logic [255:0] exp;
        exp = {{4{32'h1111_1111}}, {4{32'hAAAA_AAAA}}};
        wb(5'd5, {8{32'h1111_1111}}, 8'hFF, 1'b0);
        wb(5'd5, {8{32'hAAAA_AAAA}}, 8'h0F, 1'b0);
        set_rd(0, 5'd5); set_rd(1, 5'd5); set_rd(2, 5'd5);
        #1;
        for (int p = 0; p < 3; p++) begin
            n_cmp++; if (pd(p) !== exp) begin n_err++; $display("FAIL masked_p%0d: got %h want %h", p, pd(p), exp); end
        end
        rd_en_i[2] = 1'b0;
        #1;
        n_cmp++; if (pd(2) !== 256'h0) begin n_err++; $display("FAIL rd_disabled: got %h want 0", pd(2)); end
        rd_en_i = '0;
    endtask

    task automatic test_scoreboard();
        set_rd(0, 5'd7); set_rd(1, 5'd5);
        iss(5'd7);
        n_cmp++; if (busy_o !== 32'h0000_0080) begin n_err++; $display("FAIL sb_issue: got %h want 00000080", busy_o); end
        n_cmp++; if (rd_busy_o[1:0] !== 2'b01) begin n_err++; $display("FAIL sb_rdbusy: got %b want 01", rd_busy_o[1:0]); end
        wb(5'd7, '0, 8'h00, 1'b1);
        n_cmp++; if (busy_o !== 32'h0) begin n_err++; $display("FAIL sb_clear: got %h want 0", busy_o); end
        iss(5'd7);
        @(negedge clk);
        iss_en_i = 1'b1; iss_addr_i = 5'd7;
        wb_en_i = 1'b1; wb_addr_i = 5'd7; wb_mask_i = 8'h00; wb_last_i = 1'b1;
        @(posedge clk); #1;
        iss_en_i = 1'b0; wb_en_i = 1'b0; wb_last_i = 1'b0;
        n_cmp++; if (busy_o[7] !== 1'b1) begin n_err++; $display("FAIL sb_issue_wins: got %b want 1", busy_o[7]); end
        // Issue and last to an idle register in the same cycle is not an error.
        @(negedge clk);
        iss_en_i = 1'b1; iss_addr_i = 5'd11;
        wb_en_i = 1'b1; wb_addr_i = 5'd11; wb_last_i = 1'b1;
        @(posedge clk); #1;
        iss_en_i = 1'b0; wb_en_i = 1'b0; wb_last_i = 1'b0;
        n_cmp++; if (busy_o !== 32'h0000_0880) begin n_err++; $display("FAIL sb_idle_iss_last: got %h want 00000880", busy_o); end
        wb(5'd7, '0, 8'h00, 1'b1);
        wb(5'd11, '0, 8'h00, 1'b1);
        n_cmp++; if (busy_o !== 32'h0) begin n_err++; $display("FAIL sb_drain: got %h want 0", busy_o); end
        n_cmp++; if (sb_err_o !== 1'b0) begin n_err++; $display("FAIL sb_no_err: got %b want 0", sb_err_o); end
        rd_en_i = '0;
    endtask

    task automatic test_error();
        wb(5'd9, '0, 8'h00, 1'b1);
        n_cmp++; if (sb_err_o !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", sb_err_o); end
        repeat (12) @(posedge clk);
        #1;
        n_cmp++; if (sb_err_o !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", sb_err_o); end
        async_reset();
        n_cmp++; if (sb_err_o !== 1'b0) begin n_err++; $display("FAIL err_reset: got %b want 0", sb_err_o); end
        release_reset();
    endtask

    task automatic test_zero0();
        wb(5'd0, {256{1'b1}}, 8'hFF, 1'b0);
        iss(5'd0);
        set_rd(2, 5'd0);
        #1;
        n_cmp++; if (pd(2) !== 256'h0) begin n_err++; $display("FAIL zero_data: got %h want 0", pd(2)); end
        n_cmp++; if (rd_busy_o[2] !== 1'b0) begin n_err++; $display("FAIL zero_rdbusy: got %b want 0", rd_busy_o[2]); end
        n_cmp++; if (busy_o[0] !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b want 0", busy_o[0]); end
        n_cmp++; if (sb_err_o !== 1'b0) begin n_err++; $display("FAIL zero_err: got %b want 0", sb_err_o); end
        rd_en_i = '0;
    endtask

    task automatic test_bypass();
        logic [255:0] old_v, new_v;
        logic         exp_busy;
        old_v = {8{32'h3333_3333}};
        new_v = {{4{32'hCCCC_CCCC}}, {4{32'h3333_3333}}};
        wb(5'd3, old_v, 8'hFF, 1'b0);
        iss(5'd3);
        set_rd(1, 5'd3);
        @(negedge clk);
        wb_en_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = {8{32'hCCCC_CCCC}};
        wb_mask_i = 8'hF0; wb_last_i = 1'b1;
        #1;
`ifdef VREG_BYPASS_EN
        exp_busy = 1'b0;
        n_cmp++; if (pd(1) !== new_v) begin n_err++; $display("FAIL byp_same: got %h want %h", pd(1), new_v); end
`else
        exp_busy = 1'b1;
        n_cmp++; if (pd(1) !== old_v) begin n_err++; $display("FAIL byp_same: got %h want %h", pd(1), old_v); end
`endif
        n_cmp++; if (rd_busy_o[1] !== exp_busy) begin n_err++; $display("FAIL byp_busy: got %b want %b", rd_busy_o[1], exp_busy); end
        @(posedge clk); #1;
        wb_en_i = 1'b0; wb_last_i = 1'b0;
        #1;
        n_cmp++; if (pd(1) !== new_v) begin n_err++; $display("FAIL byp_next: got %h want %h", pd(1), new_v); end
        n_cmp++; if (rd_busy_o[1] !== 1'b0) begin n_err++; $display("FAIL byp_busy_next: got %b want 0", rd_busy_o[1]); end
        rd_en_i = '0;
    endtask

    initial begin
        test_reset();
        test_masked_write();
        test_scoreboard();
        test_error();
        test_zero0();
        test_bypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
